// File: rtl/div_seq_pkg.sv
// Shared EX-stage constants for the multi-cycle divider: state encodings,
// iteration count, the DIV/DIVU opcodes and a conditional-negate helper.
package div_seq_pkg;

    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

    localparam int DIV_ITER = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    // Two's-complement negate when neg is set; 0x80000000 maps to itself.
    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
        return neg ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shift {rem,quo} left by one, then
// keep the trial difference if the shifted remainder covers the divisor.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_next,
    output logic [WIDTH-1:0] quo_next
);

    // One guard bit above the 33-bit remainder so the borrow is explicit.
    logic [WIDTH+1:0] rem_sh;
    logic [WIDTH+1:0] trial;

    always_comb begin
        rem_sh = {rem, quo[WIDTH-1]};
        trial  = rem_sh - {2'b00, divisor};
        if (!trial[WIDTH+1]) begin
            rem_next = trial[WIDTH:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = rem_sh[WIDTH:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_seq.sv
// DIV/DIVU sequencer: accepts an operation, runs 32 div_step iterations while
// stalling IF..EX, then writes quotient to LO and remainder to HI with ready.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             flush,
    output logic             stall,
    output logic             ready,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    div_state_t       state_reg, state_next;
    logic [5:0]       cnt_reg;
    logic             sa_reg, sb_reg;
    logic [WIDTH:0]   rem_reg;
    logic [WIDTH-1:0] quo_reg, divisor_reg;
    logic [WIDTH-1:0] lo_reg, hi_reg;

    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_quo;
    logic             accept, last_iter, finish;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_reg),
        .quo      (quo_reg),
        .divisor  (divisor_reg),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    assign accept    = (state_reg == DIV_IDLE) && start && !flush;
    assign last_iter = (cnt_reg == 6'(DIV_ITER - 1));
    // Results are only committed on an un-annulled final iteration.
    assign finish    = (state_reg == DIV_BUSY) && last_iter && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= DIV_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        stall      = 1'b0;
        ready      = 1'b0;
        case (state_reg)
            DIV_IDLE: begin
                stall = start && !flush;
                if (accept) state_next = DIV_BUSY;
            end
            DIV_BUSY: begin
                stall = !flush;
                if (last_iter) state_next = DIV_DONE;
            end
            DIV_DONE: begin
                ready      = !flush;
                state_next = DIV_IDLE;
            end
            default: state_next = DIV_IDLE;
        endcase
        if (flush) state_next = DIV_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg     <= '0;
            sa_reg      <= 1'b0;
            sb_reg      <= 1'b0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            divisor_reg <= '0;
            lo_reg      <= '0;
            hi_reg      <= '0;
        end else begin
            if (accept) begin
                sa_reg      <= is_signed & opa[WIDTH-1];
                sb_reg      <= is_signed & opb[WIDTH-1];
                quo_reg     <= neg_if(opa, is_signed & opa[WIDTH-1]);
                divisor_reg <= neg_if(opb, is_signed & opb[WIDTH-1]);
                rem_reg     <= '0;
                cnt_reg     <= '0;
            end else if (state_reg == DIV_BUSY) begin
                rem_reg <= step_rem;
                quo_reg <= step_quo;
                cnt_reg <= cnt_reg + 6'd1;
            end
            if (finish) begin
                lo_reg <= neg_if(step_quo, sa_reg ^ sb_reg);
                hi_reg <= neg_if(step_rem[WIDTH-1:0], sa_reg);
            end
        end
    end

    assign lo = lo_reg;
    assign hi = hi_reg;

endmodule

// File: doc/div_seq.md
# div_seq

Multi-cycle sequencer for the DIV/DIVU instructions decoded as `EXE_DIV_OP`/`EXE_DIVU_OP`. It runs a 32-iteration restoring shift-subtract division and stalls the pipeline while busy. It delivers quotient (to LO) and remainder (to HI) with a one-cycle `ready` pulse. It sits beside the ALU in EX and feeds the HI/LO write port; the hazard unit consumes `stall`, and the exception unit drives `flush`.

## Interface
- `WIDTH`, 32, operand and result width; only 32 is supported.
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `start`  in  1  EX holds a valid DIV/DIVU; held high by the stalled pipeline for the whole operation.
- `is_signed`  in  1  1 = DIV, 0 = DIVU; sampled with `start`.
- `opa`  in  WIDTH  dividend (rs); sampled on accept.
- `opb`  in  WIDTH  divisor (rt); sampled on accept.
- `flush`  in  1  exception/eret annul; aborts any operation in progress.
- `stall`  out  1  combinational request to freeze IF..EX.
- `ready`  out  1  one-cycle pulse; `lo`/`hi` valid, HI/LO written this cycle.
- `lo`  out  WIDTH  quotient, registered.
- `hi`  out  WIDTH  remainder, registered.

## Operation
- FSM states and transitions:
  - IDLE: `start & !flush` accepts → BUSY.
  - BUSY: iteration counter reaches 31 → DONE.
  - DONE → IDLE, unconditionally.
  - `flush` in any state → IDLE.
  - `rst` overrides everything.
- Accept (IDLE):
  - Latch signs `sa = is_signed & opa[31]`, `sb = is_signed & opb[31]`.
  - Latch magnitudes `|opa|`, `|opb|`; two's-complement negate when the sign is set, so 0x80000000 stays 0x80000000 as unsigned magnitude.
  - Clear 6-bit counter; load working register `{rem[32:0]=0, quo[31:0]=|opa|}`.
- BUSY, each cycle:
  - Shift `{rem,quo}` left 1.
  - 33-bit trial `rem - {1'b0,|opb|}`.
  - Non-negative: `rem` ← trial, `quo[0]` ← 1. Otherwise `quo[0]` ← 0.
  - Counter +1.
- Entering DONE, result fix-up registered into `lo`/`hi`:
  - `lo` = `(sa^sb)` ? −quo : quo.
  - `hi` = `sa` ? −rem[31:0] : rem[31:0].
- Divide by zero: no trap; the algorithm result stands.
  - Magnitude result: quo = 0xFFFFFFFF, rem = |opa|.
  - Signed fix-ups still apply.
- `ready = (state==DONE) & !flush`.
- `lo`/`hi` hold their last value except when entering DONE. An aborted operation never modifies them.
- Reset values: state IDLE, counter 0, `lo`=0, `hi`=0, `ready`=0, `stall`=0.

## Timing
- `stall = !flush & ((state==IDLE & start) | state==BUSY)`.
- Accept at cycle T:
  - `stall` high T..T+32 (33 cycles).
  - BUSY T+1..T+32; DONE at T+33 with `ready`=1 and `stall`=0, so the pipeline advances.
- Back-to-back: the next DIV can be accepted in IDLE at T+34, i.e. one cycle after DONE. While in DONE, `start` is ignored.
- `flush` at cycle F during BUSY:
  - `stall`=0 in cycle F; IDLE at F+1.
  - `ready` never pulses; `lo`/`hi` unchanged.
- `flush` and `start` together in IDLE: no accept.
- `rst` mid-BUSY: IDLE next cycle, outputs return to reset values.

## Structure
- Shared defines header (with the other `EXE_*` constants):
  - `DIV_IDLE`/`DIV_BUSY`/`DIV_DONE` 2-bit state encodings.
  - `DIV_ITER` = 32.
  - Existing `EXE_DIV_OP`/`EXE_DIVU_OP` used by the EX glue that forms `start` and `is_signed`.
- Sub-module `div_step`: pure combinational single shift-subtract iteration, `{rem,quo}, divisor` → next `{rem,quo}`.
- `div_seq` owns the FSM, counter, sign latches, fix-up and output registers.

## Test plan
- DIVU 100/7 accepted at T → `stall` high T..T+32, `ready` at T+33, `lo`=14, `hi`=2.
- DIV −7/2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIV 7/−2 → `lo`=0xFFFFFFFD, `hi`=1. DIV 0x80000000/0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- Divide by zero:
  - DIVU 5/0 → `lo`=0xFFFFFFFF, `hi`=5.
  - DIV −5/0 → `lo`=0x00000001, `hi`=0xFFFFFFFB.
- Prior result 14/2 held; new DIVU at T; `flush` at T+10 → `stall`=0 at T+10, no `ready` ever, `lo`/`hi` remain 14/2, IDLE at T+11.
- Back-to-back DIVU 100/7 at T, then 9/3 accepted at T+34 → `ready` at T+33 (14, 2) and T+67 (3, 0); `start` during T+33 causes no extra accept.
- `rst` asserted at T+5 of an operation → next cycle IDLE, `lo`=`hi`=0, `stall`=0, `ready`=0; a new start is then accepted normally.
